// File: rtl/pattern_detector_gen.sv
// Sliding-window repeated-pattern detector: locks on PAT_LEN symbols at any alignment, then counts back-to-back copies.
// Optional feature macro PATTERN_DET_REARM_EN: pattern_found becomes a 1-cycle pulse and the detector re-arms itself.
module pattern_detector_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_valid,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [DATA_W*PAT_LEN-1:0] pattern,
  input  logic [CNT_W-1:0]          n_repeats,
  input  logic                      clear,
  output logic                      pattern_found,
  output logic                      locked,
  output logic [CNT_W-1:0]          repeat_count
);

  localparam int unsigned PW     = DATA_W * PAT_LEN;
  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam int unsigned PH_W   = $clog2(PAT_LEN);

  typedef enum logic [1:0] {SEARCH, LOCKED, FOUND} state_t;

  state_t              state;
  logic [PW-1:0]       window;
  logic [PW-1:0]       window_nxt;
  logic [PW-1:0]       shadow_pat;
  logic [CNT_W-1:0]    shadow_n;
  logic [CNT_W-1:0]    n_eff;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_nxt;
  logic [PH_W-1:0]     phase;
  logic [DATA_W-1:0]   exp_sym;
  logic                live_match;
  logic                sym_match;
  logic                last_phase;
  logic                last_copy;

  // Window after shifting in the current symbol; the fill count gates matching so a flushed window never matches.
  assign window_nxt = {window[PW-DATA_W-1:0], data_in};
  assign fill_nxt   = (fill == FILL_W'(PAT_LEN)) ? fill : fill + 1'b1;
  assign live_match = (fill_nxt == FILL_W'(PAT_LEN)) && (window_nxt == pattern);
  assign n_eff      = (n_repeats == '0) ? CNT_W'(1) : n_repeats;

  // Expected symbol for the current phase; phase 0 is the most significant symbol.
  always_comb begin
    exp_sym = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (phase == PH_W'(i)) exp_sym = shadow_pat[(PAT_LEN-1-i)*DATA_W +: DATA_W];
    end
  end

  assign sym_match  = (data_in == exp_sym);
  assign last_phase = (phase == PH_W'(PAT_LEN - 1));
  assign last_copy  = (CNT_W'(repeat_count + 1'b1) == shadow_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEARCH;
      window        <= '0;
      fill          <= '0;
      phase         <= '0;
      shadow_pat    <= '0;
      shadow_n      <= '0;
      repeat_count  <= '0;
      pattern_found <= 1'b0;
      locked        <= 1'b0;
    end else if (clear) begin
      state         <= SEARCH;
      window        <= '0;
      fill          <= '0;
      phase         <= '0;
      repeat_count  <= '0;
      pattern_found <= 1'b0;
      locked        <= 1'b0;
    end else if (state == FOUND) begin
`ifdef PATTERN_DET_REARM_EN
      // Leave FOUND after one cycle; a symbol arriving now starts the freshly flushed window.
      state         <= SEARCH;
      phase         <= '0;
      repeat_count  <= '0;
      pattern_found <= 1'b0;
      locked        <= 1'b0;
      if (data_valid) begin
        window <= window_nxt;
        fill   <= FILL_W'(1);
      end else begin
        fill   <= '0;
      end
`endif
    end else if (data_valid) begin
      window <= window_nxt;
      fill   <= fill_nxt;
      if (state == LOCKED && sym_match) begin
        if (last_phase) begin
          phase        <= '0;
          repeat_count <= repeat_count + 1'b1;
          if (last_copy) begin
            state         <= FOUND;
            pattern_found <= 1'b1;
          end
        end else begin
          phase <= phase + 1'b1;
        end
      end else if (live_match) begin
        // Fresh lock (also re-lock on the same cycle a LOCKED copy breaks).
        shadow_pat   <= pattern;
        shadow_n     <= n_eff;
        repeat_count <= CNT_W'(1);
        phase        <= '0;
        locked       <= 1'b1;
        if (n_eff == CNT_W'(1)) begin
          state         <= FOUND;
          pattern_found <= 1'b1;
        end else begin
          state <= LOCKED;
        end
      end else begin
        state        <= SEARCH;
        repeat_count <= '0;
        phase        <= '0;
        locked       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pattern_detector_gen.md
# pattern_detector_gen

Parametrised repeated-pattern detector for the PRBS/pattern test path. It watches a symbol stream with a valid qualifier and finds a PAT_LEN-symbol pattern at any alignment using a sliding window. After lock, it counts back-to-back repeats and flags detection once n_repeats consecutive copies have been seen. It sits after the data source or PRBS checker and drives the test-status logic.

## Interface
- DATA_W, 8, symbol width in bits
- PAT_LEN, 4, pattern length in symbols (≥2)
- CNT_W, 8, width of repeat count and n_repeats
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- data_valid  input  1  data_in is accepted on this cycle
- data_in  input  DATA_W  stream symbol
- pattern  input  DATA_W*PAT_LEN  pattern; MS symbol is received first
- n_repeats  input  CNT_W  required consecutive copies; 0 is treated as 1
- clear  input  1  synchronous restart to SEARCH
- pattern_found  output  1  detection flag
- locked  output  1  high in LOCKED or FOUND
- repeat_count  output  CNT_W  complete consecutive copies counted

## Operation
- Window: a PAT_LEN-symbol shift register plus a fill counter, both updated only on accepted symbols. The window is valid only after PAT_LEN symbols have been accepted since reset, clear or re-arm. An all-zero pattern never matches a flushed window.
- SEARCH: on each accepted symbol, compare the new window against the live pattern. On a match, go to LOCKED with repeat_count=1, phase=0, and capture pattern and n_repeats into shadow registers. If the effective n_repeats is 1, go directly to FOUND instead.
- LOCKED: compare each accepted symbol with shadow-pattern symbol [phase].
  - Equal, phase<PAT_LEN-1: phase++.
  - Equal, phase=PAT_LEN-1: phase=0 and repeat_count++. When repeat_count reaches the shadow n_repeats, go to FOUND.
  - Not equal: go to SEARCH with repeat_count=0. In the same cycle, check the updated window against the live pattern. On a match, re-enter LOCKED with repeat_count=1, so a periodic pattern such as AAAA is not lost.
- FOUND: pattern_found=1 and data is ignored. repeat_count holds its value.
- clear takes priority over data_valid. It returns the block to SEARCH, zeroes repeat_count, phase and the fill counter, and drops pattern_found and locked.
- repeat_count never exceeds the shadow n_repeats, so no wrap is possible.
- Changes to pattern or n_repeats while LOCKED have no effect until the block returns to SEARCH.

## Timing
- All outputs are registered. A symbol accepted at edge k is reflected in state and outputs from edge k onward; output latency is 1 cycle.
- Reset values: pattern_found=0, locked=0, repeat_count=0, state=SEARCH, window and fill counter cleared.
- data_valid=0: no state change, no window shift.
- Asserting rst_n low mid-stream clears everything immediately. The first match after release requires PAT_LEN fresh symbols.
- Minimum latency from the first symbol of copy 1 to pattern_found high is PAT_LEN*n_repeats accepted symbols.

## Configuration
- PATTERN_DET_REARM_EN defined: FOUND lasts exactly one cycle, so pattern_found is a 1-cycle pulse. The block then returns to SEARCH with repeat_count=0 and the window flushed, and detects further occurrences without clear.
- Not defined: FOUND is sticky and pattern_found stays high until clear or reset.

## Test plan
- Setup: DATA_W=8, PAT_LEN=4, pattern=32'hDEADBEEF, n_repeats=3. Stream 3 copies back to back -> locked rises after the 4th symbol; repeat_count goes 1,2,3; pattern_found high one edge after the 12th symbol.
- Prefix 8'h12, 8'hDE, then 3 copies -> detection at any alignment; pattern_found after symbol 14.
- Two copies, then 8'hDE,8'hAD,8'h00 -> return to SEARCH at the 8'h00 with repeat_count=0. A further 3 copies then assert pattern_found.
- pattern=32'hAAAAAAAA, n_repeats=2, stream 8'hAA with data_valid toggling 1/0 -> 8 accepted symbols give found; idle cycles cause no state change.
- Assert clear in FOUND, and separately pulse rst_n low mid-copy -> all outputs 0 next cycle; 4 zero symbols with pattern=0 -> match only after the 4th symbol.
- With PATTERN_DET_REARM_EN defined: 6 consecutive copies and n_repeats=3 -> two 1-cycle pattern_found pulses, after symbols 12 and 24.
